// File: rtl/remote_comm.sv
// remote_comm: bench-side UART command transmitter (16-bit, high byte first)
// and single-byte response receiver, both 8N1 with BAUD_DIV clocks per bit.
module remote_comm #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] TX_STOP_IDX = BIT_W'(9);
    localparam logic [BIT_W-1:0] TX_LAST_DATA = BIT_W'(8);
    localparam logic [BIT_W-1:0] RX_STOP_IDX = BIT_W'(8);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

    tx_state_t        tx_state, tx_state_d;
    logic [15:0]      hold, hold_d;
    logic [CNT_W-1:0] tx_baud, tx_baud_d;
    logic [BIT_W-1:0] tx_bit, tx_bit_d;
    logic             tx_d, cmd_sent_d;
    logic [7:0]       tx_byte_c;

    rx_state_t        rx_state, rx_state_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic             rx_fall_c;
    logic [CNT_W-1:0] rx_baud, rx_baud_d;
    logic [BIT_W-1:0] rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic [7:0]       resp_d;
    logic             resp_rdy_d;

    assign tx_byte_c = (tx_state == TX_HIGH) ? hold[15:8] : hold[7:0];
    assign rx_fall_c = rx_prev & ~rx_sync;

    // Transmit registers; TX holds the bit currently on the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            hold     <= 16'h0000;
            tx_baud  <= '0;
            tx_bit   <= '0;
            TX       <= 1'b1;
            cmd_sent <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            hold     <= hold_d;
            tx_baud  <= tx_baud_d;
            tx_bit   <= tx_bit_d;
            TX       <= tx_d;
            cmd_sent <= cmd_sent_d;
        end
    end

    // Command sequencing: accept in idle, send high byte then low byte back to back
    always_comb begin
        tx_state_d = tx_state;
        hold_d     = hold;
        tx_baud_d  = tx_baud;
        tx_bit_d   = tx_bit;
        tx_d       = TX;
        cmd_sent_d = cmd_sent;
        case (tx_state)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_cmd) begin
                    hold_d     = cmd;
                    cmd_sent_d = 1'b0;
                    tx_state_d = TX_HIGH;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            TX_HIGH, TX_LOW: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit == TX_STOP_IDX) begin
                        tx_bit_d = '0;
                        if (tx_state == TX_HIGH) begin
                            tx_state_d = TX_LOW;
                            tx_d       = 1'b0;
                        end else begin
                            tx_state_d = TX_IDLE;
                            tx_d       = 1'b1;
                            cmd_sent_d = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit + BIT_W'(1);
                        tx_d     = (tx_bit == TX_LAST_DATA) ? 1'b1 : tx_byte_c[tx_bit[2:0]];
                    end
                end else begin
                    tx_baud_d = tx_baud + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // RX synchronizer and edge-detect history, idle-high out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= 8'h00;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_baud  <= rx_baud_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            resp     <= resp_d;
            resp_rdy <= resp_rdy_d;
        end
    end

    // Frame receive: start on falling edge, confirm at half bit, sample mid-bit
    always_comb begin
        rx_state_d = rx_state;
        rx_baud_d  = rx_baud;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        resp_d     = resp;
        resp_rdy_d = resp_rdy;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall_c) begin
                    rx_state_d = RX_START;
                    rx_baud_d  = '0;
                    resp_rdy_d = 1'b0;
                end
            end
            RX_START: begin
                if (rx_baud == HALF_LAST) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_d = '0;
                    if (rx_bit == RX_STOP_IDX) begin
                        // stop bit value is not checked
                        resp_d     = rx_shift;
                        resp_rdy_d = 1'b1;
                        rx_bit_d   = '0;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_shift_d = {rx_sync, rx_shift[7:1]};
                        rx_bit_d   = rx_bit + BIT_W'(1);
                    end
                end else begin
                    rx_baud_d = rx_baud + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm with a short bit period.
module tb_remote_comm;

    localparam int unsigned B = 16;
    localparam int LIMIT = 40 * B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int sent_cyc = 0;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
        .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse send_cmd for one clock; start bit must be on the line next cycle
    task automatic send(input logic [15:0] w);
        cmd = w;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        cmd = 16'hFFFF;
        check("tx_start", 16'(TX), 16'd0);
        start_cyc = cyc;
    endtask

    // decode one TX byte at mid-bit; call at a negedge
    task automatic tx_get(input string tag, input logic [7:0] exp);
        int n = 0;
        logic [7:0] b;
        logic stop;
        while (TX !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 16'(n < LIMIT), 16'd1);
        repeat (B / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
        end
        repeat (B) @(negedge clk);
        stop = TX;
        check(tag, 16'(b), 16'(exp));
        check({tag, "_stop"}, 16'(stop), 16'd1);
    endtask

    task automatic wait_sent();
        int n = 0;
        while (cmd_sent !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("sent_timeout", 16'(n < LIMIT), 16'd1);
        sent_cyc = cyc;
    endtask

    // drive one 8N1 frame on RX, changing at negedges
    task automatic rx_send(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    // watch idle lines for a window
    task automatic quiet(input string tag, input int cycles);
        int lows = 0;
        int drops = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
            if (cmd_sent !== 1'b1) drops++;
        end
        check({tag, "_tx_low"}, 16'(lows), 16'd0);
        if (tag == "busy") check("busy_sent_drop", 16'(drops), 16'd0);
    endtask

    initial begin
        // reset
        repeat (5) @(negedge clk);
        check("rst_tx", 16'(TX), 16'd1);
        check("rst_sent", 16'(cmd_sent), 16'd0);
        check("rst_rdy", 16'(resp_rdy), 16'd0);
        check("rst_resp", 16'(resp), 16'h00);
        rst_n = 1'b1;
        quiet("post_rst", 50 * B);
        check("post_rst_sent", 16'(cmd_sent), 16'd0);

        // calibrate command
        send(16'h2000);
        tx_get("cal_hi", 8'h20);
        tx_get("cal_lo", 8'h00);
        wait_sent();
        check("cal_sent_time", 16'((sent_cyc - start_cyc >= 20 * B - 1) && (sent_cyc - start_cyc <= 20 * B + 1)), 16'd1);
        repeat (2 * B) @(negedge clk);
        check("cal_sent_hold", 16'(cmd_sent), 16'd1);
        check("cal_tx_idle", 16'(TX), 16'd1);

        // acknowledge receive, then a second frame clears ready at its start
        rx_send(8'hA5);
        repeat (2) @(negedge clk);
        check("ack_resp", 16'(resp), 16'hA5);
        check("ack_rdy", 16'(resp_rdy), 16'd1);
        fork
            rx_send(8'h5A);
            begin
                repeat (6) @(negedge clk);
                check("ack2_rdy_clr", 16'(resp_rdy), 16'd0);
                check("ack2_resp_hold", 16'(resp), 16'hA5);
            end
        join
        repeat (2) @(negedge clk);
        check("ack2_resp", 16'(resp), 16'h5A);
        check("ack2_rdy", 16'(resp_rdy), 16'd1);

        // busy ignore
        send(16'h1234);
        check("busy_sent_clr", 16'(cmd_sent), 16'd0);
        fork
            tx_get("busy_hi", 8'h12);
            begin
                repeat (40) @(negedge clk);
                cmd = 16'hBEEF;
                send_cmd = 1'b1;
                @(negedge clk);
                send_cmd = 1'b0;
                cmd = 16'h0000;
            end
        join
        tx_get("busy_lo", 8'h34);
        wait_sent();
        quiet("busy", 30 * B);

        // glitch rejection
        RX = 1'b0;
        repeat (B / 4 - 1) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("glitch_resp", 16'(resp), 16'h5A);
        check("glitch_rdy", 16'(resp_rdy), 16'd0);
        rx_send(8'h3C);
        repeat (2) @(negedge clk);
        check("post_glitch_resp", 16'(resp), 16'h3C);
        check("post_glitch_rdy", 16'(resp_rdy), 16'd1);

        // reset during low byte
        send(16'hABCD);
        repeat (13 * B) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 16'(TX), 16'd1);
        check("mid_rst_sent", 16'(cmd_sent), 16'd0);
        check("mid_rst_rdy", 16'(resp_rdy), 16'd0);
        check("mid_rst_resp", 16'(resp), 16'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet("mid_rst_idle", 30 * B);
        check("mid_rst_sent_low", 16'(cmd_sent), 16'd0);

        // new command with a concurrent response
        send(16'h0102);
        fork
            begin
                tx_get("re_hi", 8'h01);
                tx_get("re_lo", 8'h02);
            end
            rx_send(8'hA5);
        join
        wait_sent();
        check("re_sent_time", 16'((sent_cyc - start_cyc >= 20 * B - 1) && (sent_cyc - start_cyc <= 20 * B + 1)), 16'd1);
        check("re_resp", 16'(resp), 16'hA5);
        check("re_rdy", 16'(resp_rdy), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
# remote_comm

Bench-side remote-control transmitter/receiver that sends 16-bit commands to the knight's UART and returns its 8-bit responses, such as the 0xA5 positive acknowledge after calibration. Each command is serialized as two 8N1 UART bytes, high byte first. One response byte at a time is deserialized and flagged to the host. The block instantiates one UART transmitter path, one UART receiver path and a small command-sequencing state machine.

## Interface
- BAUD_DIV, default 434: clocks per UART bit; width 12 bits.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- RX  input  1  serial in from DUT TX; idle high; asynchronous to clk.
- TX  output  1  serial out to DUT RX; idle high.
- cmd  input  16  command word to send; sampled when send_cmd is high.
- send_cmd  input  1  start request; level sampled each clock.
- cmd_sent  output  1  high once both bytes of the last command are fully transmitted.
- resp_rdy  output  1  a new response byte is valid on resp.
- resp  output  8  last received response byte.

## Operation
- Frame format is 8N1: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts BAUD_DIV clocks.
- Command FSM states:
  - IDLE: TX=1. When send_cmd=1, latch cmd into a 16-bit holding register, clear cmd_sent, go to HIGH.
  - HIGH: transmit cmd[15:8]. When its stop bit completes, go to LOW.
  - LOW: transmit cmd[7:0]. When its stop bit completes, set cmd_sent and go to IDLE.
- send_cmd outside IDLE is ignored. The holding register is unaffected, and cmd changes during transmission have no effect.
- cmd_sent stays high until the next accepted send_cmd.
- Receiver path:
  - RX is double-flop synchronized; the synchronizer flops preset to 1 on reset.
  - A falling edge of the synchronized RX while the receiver is idle starts a frame.
  - The start bit is re-checked at BAUD_DIV/2 clocks. If it is high, the frame is aborted and the receiver returns to idle.
  - Bits are sampled mid-bit, every BAUD_DIV clocks after the start-bit check: 8 data bits, then the stop bit.
- On the stop-bit sample, resp is loaded with the shift register and resp_rdy is set. No framing-error reporting: a 0 stop bit is still accepted.
- resp_rdy clears at the falling edge that begins the next received frame, or on reset. resp holds its value until the next completed frame.
- TX and RX paths are fully independent. Receiving during transmission is legal.

## Timing
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00, FSM=IDLE, both bit counters and baud counters 0.
- TX start bit begins the clock after send_cmd is sampled in IDLE.
- The LOW byte start bit follows immediately after the HIGH byte stop bit: 0 idle clocks between bytes.
- cmd_sent rises 20×BAUD_DIV clocks after the TX start-bit edge, within ±1 clock.
- resp_rdy rises about 9.5×BAUD_DIV clocks after the RX start falling edge, plus 2 synchronizer clocks.
- Reset asserted mid-operation: all outputs return to reset values immediately, and any partial frame in either direction is discarded. After release, TX stays high until a new send_cmd.
- send_cmd held high continuously: a new command is accepted in the first IDLE cycle after completion. cmd_sent is then high for exactly 1 clock.

## Test plan
- Reset check: hold rst_n=0, then release -> TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, with no TX activity for 50×BAUD_DIV clocks.
- Calibrate command: cmd=16'h2000, 1-clock send_cmd pulse.
  - Decode TX at mid-bit -> byte 0x20, then byte 0x00, with valid stop bits.
  - cmd_sent rises 20×BAUD_DIV ±1 clocks after the first start edge and stays high.
- Acknowledge receive: drive an 8N1 frame of 0xA5 on RX -> resp=0xA5 and resp_rdy=1 after the stop-bit sample. A following 0x5A frame clears resp_rdy at its start edge, then yields resp=0x5A.
- Busy ignore: send_cmd with cmd=16'h1234, then a second send_cmd with 16'hBEEF during the HIGH byte -> TX carries only 0x12, 0x34. The 0xBEEF command is never sent, and cmd_sent rises once.
- Glitch rejection: an RX low pulse shorter than BAUD_DIV/4 clocks -> no resp_rdy and resp unchanged. A valid frame immediately afterwards is received correctly.
- Reset mid-command: assert rst_n during the LOW byte of 16'hABCD -> TX=1 immediately and cmd_sent=0. After release, a new command 16'h0102 transmits correctly.
